// File: rtl/fetch_seq_pkg.sv
// Shared constants for the instruction fetch sequencer: opcode map,
// state encoding and retired-instruction counter width.
package fetch_seq_pkg;

    localparam int COUNT_W = 16;
    localparam int OPC_W   = 4;
    localparam int INSTR_W = 16;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU   = 4'h1;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h3;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OPC_W-1:0] OP_JUMP  = 4'h5;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_seq_decode.sv
// Opcode classifier: one-hot class flags for the registered opcode.
module fetch_seq_decode
    import fetch_seq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_nop,
    output logic             is_alu,
    output logic             is_load,
    output logic             is_store,
    output logic             is_beq,
    output logic             is_jump,
    output logic             is_halt,
    output logic             is_illegal
);

    // Classify the opcode; anything outside the map is illegal.
    always_comb begin
        is_nop     = 1'b0;
        is_alu     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_beq     = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:   is_nop     = 1'b1;
            OP_ALU:   is_alu     = 1'b1;
            OP_LOAD:  is_load    = 1'b1;
            OP_STORE: is_store   = 1'b1;
            OP_BEQ:   is_beq     = 1'b1;
            OP_JUMP:  is_jump    = 1'b1;
            OP_HALT:  is_halt    = 1'b1;
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer driving the fetch unit and datapath
// strobes. Each instruction has exactly one PC update cycle (Halt=0).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for Start; Start pulses Init (PC clear)
// FETCH   | IR_LD, opcode register captures Instr[15:12]
// DECODE  | classify; NOP retires here, HALT/illegal go to HALTED
// EXEC    | ALU/LOAD/STORE pass through; BEQ/JUMP retire here
// MEM     | STORE retires with MemWrite; LOAD passes through
// WB      | ALU/LOAD retire with RegWrite
// HALTED  | PC held; Resume steps PC+1 and returns to FETCH
module fetch_sequencer
    import fetch_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               Init_n,
    input  logic               Start,
    input  logic               Resume,
    input  logic [INSTR_W-1:0] Instr,
    output logic               Init,
    output logic               Halt,
    output logic               Beq,
    output logic               PC_CTRL,
    output logic               IR_LD,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               Busy,
    output logic               Illegal,
    output logic [COUNT_W-1:0] InstrCount
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic is_nop, is_alu, is_load, is_store;
    logic is_beq, is_jump, is_halt, is_illegal;
    logic retire;
    logic resume_step;

    // Only the opcode field matters to sequencing; operands belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[INSTR_W-OPC_W-1:0];

    fetch_seq_decode u_decode (
        .opcode     (opcode_q),
        .is_nop     (is_nop),
        .is_alu     (is_alu),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_beq     (is_beq),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // State, opcode, sticky illegal flag and retire counter.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state sequencing per opcode class.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                opcode_d = Instr[INSTR_W-1:INSTR_W-OPC_W];
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_nop) begin
                    state_d = ST_FETCH;
                end else if (is_halt) begin
                    state_d = ST_HALTED;
                end else if (is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALTED;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_alu)                  state_d = ST_WB;
                else if (is_load || is_store) state_d = ST_MEM;
                else                          state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (is_load) state_d = ST_WB;
                else         state_d = ST_FETCH;
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                if (Resume) begin
                    illegal_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output strobes decoded from registered state/opcode; Start and Resume
    // are the only live inputs, and Init is masked while reset is held.
    always_comb begin
        Init        = 1'b0;
        Beq         = 1'b0;
        PC_CTRL     = 1'b0;
        IR_LD       = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        retire      = 1'b0;
        resume_step = 1'b0;
        case (state_q)
            ST_IDLE:   Init  = Start & Init_n;
            ST_FETCH:  IR_LD = 1'b1;
            ST_DECODE: retire = is_nop;
            ST_EXEC: begin
                Beq     = is_beq;
                PC_CTRL = is_jump;
                retire  = is_beq | is_jump;
            end
            ST_MEM: begin
                MemWrite = is_store;
                retire   = is_store;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            ST_HALTED: resume_step = Resume;
            default: ;
        endcase
        Halt = ~(retire | resume_step);
    end

    // Resume steps the PC but is not a retired instruction.
    always_comb begin
        count_d = retire ? sat_inc(count_q) : count_q;
    end

    assign Busy       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign Illegal    = illegal_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer. The expected per-cycle
// strobe pattern of each instruction comes from an opcode table (cycle count,
// which strobe fires in the final cycle, whether that cycle updates the PC).
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Init_n;
    logic        Start;
    logic        Resume;
    logic [15:0] Instr;
    logic        Init, Halt, Beq, PC_CTRL, IR_LD, RegWrite, MemWrite, Busy, Illegal;
    logic [15:0] InstrCount;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'h0;
    logic        exp_ill = 1'b0;

    fetch_sequencer dut (
        .CLK        (CLK),
        .Init_n     (Init_n),
        .Start      (Start),
        .Resume     (Resume),
        .Instr      (Instr),
        .Init       (Init),
        .Halt       (Halt),
        .Beq        (Beq),
        .PC_CTRL    (PC_CTRL),
        .IR_LD      (IR_LD),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Busy       (Busy),
        .Illegal    (Illegal),
        .InstrCount (InstrCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".init"},     16'(Init),     16'h0);
        chk({tag, ".halt"},     16'(Halt),     16'h1);
        chk({tag, ".beq"},      16'(Beq),      16'h0);
        chk({tag, ".pc_ctrl"},  16'(PC_CTRL),  16'h0);
        chk({tag, ".ir_ld"},    16'(IR_LD),    16'h0);
        chk({tag, ".regwrite"}, 16'(RegWrite), 16'h0);
        chk({tag, ".memwrite"}, 16'(MemWrite), 16'h0);
        chk({tag, ".busy"},     16'(Busy),     16'h0);
        chk({tag, ".illegal"},  16'(Illegal),  16'h0);
        chk({tag, ".count"},    InstrCount,    16'h0);
    endtask

    // From IDLE: pulse Start for one cycle, expect Init during it.
    task automatic do_start();
        @(negedge CLK);
        Start = 1'b1;
        #1;
        chk("start.init", 16'(Init), 16'h1);
        chk("start.halt", 16'(Halt), 16'h1);
        chk("start.busy", 16'(Busy), 16'h0);
        @(posedge CLK);
        #1 Start = 1'b0;
    endtask

    // Run one instruction from its FETCH cycle to its last cycle.
    task automatic run_instr(input logic [15:0] word);
        int   n;
        logic upd, rw, mw, bq, pj, ill, last;
        upd = 1'b1; rw = 1'b0; mw = 1'b0; bq = 1'b0; pj = 1'b0; ill = 1'b0;
        case (word[15:12])
            4'h0: n = 2;
            4'h1: begin n = 4; rw = 1'b1; end
            4'h2: begin n = 5; rw = 1'b1; end
            4'h3: begin n = 4; mw = 1'b1; end
            4'h4: begin n = 3; bq = 1'b1; end
            4'h5: begin n = 3; pj = 1'b1; end
            4'hF: begin n = 2; upd = 1'b0; end
            default: begin n = 2; upd = 1'b0; ill = 1'b1; end
        endcase
        Instr = word;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            last = (c == n - 1);
            chk("ir_ld",    16'(IR_LD),    16'(c == 0));
            chk("halt",     16'(Halt),     16'(!(last && upd)));
            chk("regwrite", 16'(RegWrite), 16'(last && rw));
            chk("memwrite", 16'(MemWrite), 16'(last && mw));
            chk("beq",      16'(Beq),      16'(last && bq));
            chk("pc_ctrl",  16'(PC_CTRL),  16'(last && pj));
            chk("init",     16'(Init),     16'h0);
            chk("busy",     16'(Busy),     16'h1);
            chk("illegal",  16'(Illegal),  16'(exp_ill));
            chk("count",    InstrCount,    exp_cnt);
            if (last) begin
                if (upd && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
                if (ill) exp_ill = 1'b1;
                Start  = 1'b0;
                Resume = 1'b0;
            end else begin
                if (c > 0) Instr = 16'($urandom);
                Start  = 1'($urandom);
                Resume = 1'($urandom);
            end
        end
    endtask

    // Sit in HALTED for some cycles (Start ignored), then Resume.
    task automatic halted_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            Start  = 1'($urandom);
            Resume = 1'b0;
            #1;
            chk("hlt.halt",    16'(Halt),    16'h1);
            chk("hlt.busy",    16'(Busy),    16'h0);
            chk("hlt.init",    16'(Init),    16'h0);
            chk("hlt.ir_ld",   16'(IR_LD),   16'h0);
            chk("hlt.illegal", 16'(Illegal), 16'(exp_ill));
            chk("hlt.count",   InstrCount,   exp_cnt);
        end
        @(negedge CLK);
        Start  = 1'b0;
        Resume = 1'b1;
        #1;
        chk("resume.halt",  16'(Halt),   16'h0);
        chk("resume.busy",  16'(Busy),   16'h0);
        chk("resume.count", InstrCount,  exp_cnt);
        @(posedge CLK);
        #1 Resume = 1'b0;
        exp_ill = 1'b0;
    endtask

    initial begin
        Init_n = 1'b0;
        Start  = 1'b0;
        Resume = 1'b0;
        Instr  = 16'h0;
        #12;
        chk_quiet("reset");
        Start = 1'b1;
        #1;
        chk("reset.init_masked", 16'(Init), 16'h0);
        Start = 1'b0;

        @(negedge CLK);
        Init_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            Resume = 1'($urandom);
            #1;
            chk("idle.halt", 16'(Halt), 16'h1);
            chk("idle.busy", 16'(Busy), 16'h0);
        end
        Resume = 1'b0;

        do_start();
        run_instr(16'h0123);
        run_instr(16'h1456);
        run_instr(16'h2789);
        run_instr(16'h3abc);
        chk("prog4.count", 16'(exp_cnt), 16'h4);
        run_instr(16'h4003);
        run_instr(16'h5000);
        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 5));
            run_instr({op, 12'($urandom)});
        end

        run_instr(16'hF000);
        halted_phase(10);
        run_instr(16'h0000);

        run_instr(16'h9000);
        halted_phase(4);
        run_instr(16'h1001);
        begin
            logic [3:0] bad;
            bad = 4'($urandom_range(6, 14));
            run_instr({bad, 12'($urandom)});
        end
        halted_phase(2);
        run_instr(16'h3210);

        Instr = 16'h2abc;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        chk("mem.memwrite", 16'(MemWrite), 16'h0);
        chk("mem.halt",     16'(Halt),     16'h1);
        #2 Init_n = 1'b0;
        #1;
        chk_quiet("midreset");
        exp_cnt = 16'h0;
        exp_ill = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk_quiet("inreset");
        end
        Init_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk_quiet("postreset");
        end
        do_start();
        run_instr(16'h0fff);
        @(negedge CLK);
        chk("final.count", InstrCount, exp_cnt);
        chk("final.ir_ld", 16'(IR_LD), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge active.
REQ-002 SHALL have port: Init_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: Start  in  1  begin execution from PC 0; honoured only in IDLE.
REQ-004 SHALL have port: Resume  in  1  leave HALTED; honoured only in HALTED.
REQ-005 SHALL have port: Instr  in  16  instruction word from instruction memory; opcode = Instr[15:12].
REQ-006 SHALL have ports: Init, Halt, Beq, PC_CTRL  out  1 each  fetch-unit controls (PC clear, PC hold, conditional relative branch, absolute load).
REQ-007 SHALL have ports: IR_LD, RegWrite, MemWrite  out  1 each  datapath strobes.
REQ-008 SHALL have ports: Busy  out  1  not IDLE/HALTED; Illegal  out  1  sticky illegal-opcode flag; InstrCount  out  16  retired instructions.

Function
REQ-009 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED; one instruction's PC update occurs in exactly one cycle (the "update cycle", Halt=0); Halt=1 in every other cycle.
REQ-010 IDLE: Start=1 -> Init=1 for that cycle, next FETCH; else stay.
REQ-011 FETCH: IR_LD=1, opcode register captures Instr[15:12] at the rising edge; next DECODE.
REQ-012 Opcodes: 0000 NOP, 0001 ALU, 0010 LOAD, 0011 STORE, 0100 BEQ, 0101 JUMP, 1111 HALT; all others illegal.
REQ-013 NOP: DECODE is the update cycle; next FETCH (2 cycles total).
REQ-014 ALU: DECODE -> EXEC -> WB; WB asserts RegWrite=1 and is the update cycle (4 cycles).
REQ-015 LOAD: DECODE -> EXEC -> MEM -> WB; WB asserts RegWrite=1 and is the update cycle (5 cycles).
REQ-016 STORE: DECODE -> EXEC -> MEM; MEM asserts MemWrite=1 and is the update cycle (4 cycles).
REQ-017 BEQ: DECODE -> EXEC; EXEC asserts Beq=1 and is the update cycle; the branch decision belongs to the fetch unit (3 cycles).
REQ-018 JUMP: DECODE -> EXEC; EXEC asserts PC_CTRL=1 and is the update cycle (3 cycles).
REQ-019 HALT: DECODE -> HALTED with no update cycle; PC holds on the HALT instruction.
REQ-020 Illegal opcode: DECODE sets Illegal=1 and goes to HALTED with no update cycle.
REQ-021 HALTED: Resume=0 -> stay, Halt=1. Resume=1 -> that cycle is an update cycle (PC+1), Illegal cleared, next FETCH.
REQ-022 Beq, PC_CTRL, RegWrite, MemWrite, IR_LD, Init SHALL be 0 except in the cycles named above; no two of Init/Beq/PC_CTRL are asserted together.
REQ-023 InstrCount SHALL increment by 1 at the end of every update cycle except the Resume cycle; it saturates at 16'hFFFF.
REQ-024 Start in any state other than IDLE, and Resume in any state other than HALTED, SHALL be ignored.
REQ-025 Outputs SHALL be combinational decodes of the registered state and opcode only, with no input-to-output path except Start->Init in IDLE and Resume->Halt in HALTED.

Reset
REQ-026 Init_n=0 SHALL force IDLE immediately: Halt=1; Init, Beq, PC_CTRL, IR_LD, RegWrite, MemWrite, Busy, Illegal=0; InstrCount=0; opcode register=0.
REQ-027 Reset mid-instruction SHALL abandon it with no strobe emitted after assertion; execution restarts only through Start.
REQ-028 Start SHALL not be honoured in the first cycle after deassertion if Init_n deasserts within that clock's setup window; otherwise the first edge after deassertion is live.

Structure
REQ-029 Package fetch_seq_pkg SHALL hold the opcode constants, the state encoding, and the InstrCount width.
REQ-030 Opcode classification SHALL be a combinational sub-module fetch_seq_decode (opcode in; is_nop/alu/load/store/beq/jump/halt/illegal out).

Verification
REQ-031 Reset, then Start=1 for 1 cycle -> Init=1 for that cycle; next cycle FETCH with IR_LD=1; Busy=1.
REQ-032 Program NOP, ALU, LOAD, STORE -> update cycles 2, 4, 5, 4 cycles apart; RegWrite in ALU/LOAD WB; MemWrite in STORE MEM; InstrCount=4.
REQ-033 BEQ (Instr=16'h4003) -> Beq=1 in exactly the EXEC cycle with Halt=0; JUMP (16'h5000) -> PC_CTRL=1 in EXEC; the other signal stays 0.
REQ-034 HALT (16'hF000) -> HALTED, Halt=1 held 10 cycles, Busy=0; Resume=1 -> one cycle with Halt=0, then FETCH; InstrCount unchanged by Resume.
REQ-035 Opcode 4'h9 -> Illegal=1, HALTED; Start ignored while halted; Resume clears Illegal.
REQ-036 Init_n pulsed low during LOAD MEM -> all strobes 0 at once, IDLE, InstrCount=0; no RegWrite follows.
